// File: rtl/register_file_mp.sv
// Two-write, two-read register file with a sequential clear engine after reset.
// Write port 1 wins over port 0 on the same address; optional zero register and read bypass.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     select_a,
    input  logic [AW-1:0]     select_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [AW-1:0]     select_w0,
    input  logic [DATA_W-1:0] data_write0,
    input  logic              write0,
    input  logic [AW-1:0]     select_w1,
    input  logic [DATA_W-1:0] data_write1,
    input  logic              write1,
    output logic              ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] sel);
        return {1'b0, sel} < DEPTH_L;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    assign ready = (state_q == RUN);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns state_d/clr_cnt_d and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    logic we0, we1;
    assign we0 = ready && write0 && in_range(select_w0) && !is_zero_reg(select_w0);
    assign we1 = ready && write1 && in_range(select_w1) && !is_zero_reg(select_w1);

    // NOTE: the array has no reset branch; the clear engine zeroes it one entry per cycle,
    // which keeps it mappable to plain RAM/flops without a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                if (we0) mem_q[select_w0] <= data_write0;
                // Later assignment wins, giving port 1 priority on an address collision.
                if (we1) mem_q[select_w1] <= data_write1;
            end
        end
    end

    logic [AW-1:0]     rd_sel  [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_sel[0] = select_a;
    assign rd_sel[1] = select_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (!ready || is_zero_reg(rd_sel[p]) || !in_range(rd_sel[p])) begin
                rd_data[p] = '0;
            end else if ((BYPASS != 0) && write1 && (select_w1 == rd_sel[p])) begin
                rd_data[p] = data_write1;
            end else if ((BYPASS != 0) && write0 && (select_w0 == rd_sel[p])) begin
                rd_data[p] = data_write0;
            end else begin
                rd_data[p] = mem_q[rd_sel[p]];
            end
        end
    end

    assign data_a = rd_data[0];
    assign data_b = rd_data[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: one instance with zero register and bypass, one 20-entry instance
// without either, both driven by the same stimulus.
module tb_register_file_mp;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] select_a, select_b, select_w0, select_w1;
    logic [31:0]   data_write0, data_write1;
    logic          write0, write1;

    logic [31:0]   data_a1, data_b1, data_a2, data_b2;
    logic          ready1, ready2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst),
        .select_a(select_a), .select_b(select_b),
        .data_a(data_a1), .data_b(data_b1),
        .select_w0(select_w0), .data_write0(data_write0), .write0(write0),
        .select_w1(select_w1), .data_write1(data_write1), .write1(write1),
        .ready(ready1)
    );

    register_file_mp #(.DATA_W(32), .DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut2 (
        .clk(clk), .rst(rst),
        .select_a(select_a), .select_b(select_b),
        .data_a(data_a2), .data_b(data_b2),
        .select_w0(select_w0), .data_write0(data_write0), .write0(write0),
        .select_w1(select_w1), .data_write1(data_write1), .write1(write1),
        .ready(ready2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        write0 = 1'b0;
        write1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        select_a = '0; select_b = '0;
        select_w0 = '0; select_w1 = '0;
        data_write0 = '0; data_write1 = '0;
        idle_writes();

        // Reset held for two edges
        step();
        step();
        check("rst_ready1", ready1, 0);
        check("rst_ready2", ready2, 0);
        check("rst_data_a1", data_a1, 0);

        // Clear sequence; writes to addr 2 attempted on edges 11..19 must be ignored
        rst = 1'b0;
        select_a = 5'd2;
        select_w0 = 5'd2;
        data_write0 = 32'hCAFE_F00D;
        for (int i = 1; i <= 32; i++) begin
            write0 = (i >= 11 && i <= 19);
            step();
            check($sformatf("clr_ready1_e%0d", i), ready1, (i >= 32) ? 1 : 0);
            if (i == 19 || i == 20)
                check($sformatf("clr_ready2_e%0d", i), ready2, (i >= 20) ? 1 : 0);
            if (i == 15)
                check("clr_bypass_blocked", data_a1, 0);
        end
        idle_writes();
        #1;
        check("clr_write_ignored1", data_a1, 0);
        check("clr_write_ignored2", data_a2, 0);
        for (int a = 0; a < 32; a++) begin
            select_a = a[AW-1:0];
            select_b = a[AW-1:0];
            #1;
            check($sformatf("cleared1_%0d", a), data_a1, 0);
            check($sformatf("cleared2_%0d", a), data_b2, 0);
        end

        // Single write, then read on both ports
        select_w0 = 5'd5; data_write0 = 32'hDEAD_BEEF; write0 = 1'b1;
        select_a = 5'd5; select_b = 5'd6;
        #1;
        check("w5_bypass1", data_a1, 32'hDEAD_BEEF);
        check("w5_nobypass2", data_a2, 0);
        step();
        idle_writes();
        #1;
        check("w5_read1", data_a1, 32'hDEAD_BEEF);
        check("w5_read2", data_a2, 32'hDEAD_BEEF);
        check("w6_read1", data_b1, 0);
        check("w6_read2", data_b2, 0);

        // Write collision: port 1 wins
        select_w0 = 5'd7; data_write0 = 32'h11; write0 = 1'b1;
        select_w1 = 5'd7; data_write1 = 32'h22; write1 = 1'b1;
        select_a = 5'd7; select_b = 5'd7;
        #1;
        check("col_bypass1", data_a1, 32'h22);
        check("col_nobypass2", data_b2, 0);
        step();
        idle_writes();
        #1;
        check("col_read1", data_a1, 32'h22);
        check("col_read2", data_b2, 32'h22);

        // Zero register
        select_w0 = 5'd0; data_write0 = 32'hFFFF_FFFF; write0 = 1'b1;
        select_a = 5'd0;
        #1;
        check("zero_same1", data_a1, 0);
        check("zero_same2", data_a2, 0);
        step();
        idle_writes();
        #1;
        check("zero_next1", data_a1, 0);
        check("zero_next2", data_a2, 32'hFFFF_FFFF);

        // Bypass vs registered visibility
        select_w0 = 5'd3; data_write0 = 32'hA5; write0 = 1'b1;
        select_a = 5'd3;
        #1;
        check("byp_same1", data_a1, 32'hA5);
        check("byp_same2", data_a2, 0);
        step();
        idle_writes();
        #1;
        check("byp_next1", data_a1, 32'hA5);
        check("byp_next2", data_a2, 32'hA5);

        // Two different addresses in one edge, plus out-of-range write on dut2
        select_w0 = 5'd10; data_write0 = 32'h0000_AAAA; write0 = 1'b1;
        select_w1 = 5'd11; data_write1 = 32'h0000_BBBB; write1 = 1'b1;
        step();
        select_w0 = 5'd25; data_write0 = 32'h5555_5555; write0 = 1'b1;
        write1 = 1'b0;
        select_a = 5'd25;
        #1;
        check("oor_same2", data_a2, 0);
        check("oor_bypass1", data_a1, 32'h5555_5555);
        step();
        idle_writes();
        select_a = 5'd10; select_b = 5'd11;
        #1;
        check("dual_a1", data_a1, 32'h0000_AAAA);
        check("dual_b1", data_b1, 32'h0000_BBBB);
        check("dual_a2", data_a2, 32'h0000_AAAA);
        check("dual_b2", data_b2, 32'h0000_BBBB);
        select_a = 5'd25; select_b = 5'd5;
        #1;
        check("oor_read1", data_a1, 32'h5555_5555);
        check("oor_read2", data_a2, 0);
        check("oor_noalias2", data_b2, 32'hDEAD_BEEF);

        // Reset mid-RUN, then again mid-CLEAR at clr_cnt == 10
        select_w0 = 5'd9; data_write0 = 32'h1234; write0 = 1'b1;
        step();
        idle_writes();
        select_a = 5'd9;
        #1;
        check("fill9", data_a1, 32'h1234);
        rst = 1'b1;
        step();
        rst = 1'b0;
        select_a = 5'd5;
        #1;
        check("rerst_ready1", ready1, 0);
        check("rerst_data1", data_a1, 0);
        for (int i = 1; i <= 10; i++) step();
        check("midclr_ready2", ready2, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 19 || i == 20)
                check($sformatf("rst2_ready2_e%0d", i), ready2, (i >= 20) ? 1 : 0);
            if (i == 31 || i == 32)
                check($sformatf("rst2_ready1_e%0d", i), ready1, (i >= 32) ? 1 : 0);
        end
        select_a = 5'd9; select_b = 5'd10;
        #1;
        check("post_a9_1", data_a1, 0);
        check("post_a9_2", data_a2, 0);
        check("post_a10_1", data_b1, 0);
        check("post_a10_2", data_b2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
